// File: rtl/hist_accum.sv
// Streaming histogram: counts samples per bin in RAM, then streams and clears all bins.
// Optional HIST_SATURATE_EN: saturating counters with a sticky o_overflow flag.
module hist_accum #(
  parameter int DATA_W = 8,
  parameter int BIN_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  output logic              o_ready,
  output logic              o_bin_valid,
  output logic [BIN_W-1:0]  o_bin_idx,
  output logic [CNT_W-1:0]  o_bin_count,
  output logic              o_bin_last,
  input  logic              i_ready,
  output logic              o_overflow
);
  localparam int NBINS = 1 << BIN_W;

  typedef enum logic [1:0] {S_INIT, S_ACCUM, S_DRAIN, S_READ} state_t;

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  init_idx_q, init_idx_d;
  logic              drain_q, drain_d;
  logic              s1_valid_q, s1_valid_d;
  logic [BIN_W-1:0]  s1_bin_q, s1_bin_d;
  logic              fwd_valid_q, fwd_valid_d;
  logic [BIN_W-1:0]  fwd_bin_q, fwd_bin_d;
  logic [CNT_W-1:0]  fwd_cnt_q, fwd_cnt_d;
  logic [BIN_W:0]    fetch_idx_q, fetch_idx_d;
  logic              pend_valid_q, pend_valid_d;
  logic [BIN_W-1:0]  pend_idx_q, pend_idx_d;
  logic              out_valid_q, out_valid_d;
  logic [BIN_W-1:0]  out_idx_q, out_idx_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic              out_last_q, out_last_d;

  logic [CNT_W-1:0]  mem [NBINS];
  logic [CNT_W-1:0]  rd_data_q;
  logic [BIN_W-1:0]  rd_addr, wr_addr, in_bin;
  logic [CNT_W-1:0]  wr_data, base, incr;
  logic              we, accept, xfer, read_eng, load;
  logic              data_unused;

  assign in_bin      = i_data[DATA_W-1 -: BIN_W];
  assign data_unused = ^i_data;
  assign o_ready     = (state_q == S_ACCUM);
  assign accept      = o_ready && i_valid;
  assign xfer        = out_valid_q && i_ready;
  // Bin 0 is fetched in the last drain cycle, right after the final update lands.
  assign read_eng    = (state_q == S_READ) || (state_q == S_DRAIN && drain_q);
  assign load        = pend_valid_q && (!out_valid_q || xfer);

  // The RAM reads old data on a same-cycle write, so only the previous write needs forwarding.
  always_comb begin
    base = (fwd_valid_q && fwd_bin_q == s1_bin_q) ? fwd_cnt_q : rd_data_q;
`ifdef HIST_SATURATE_EN
    incr = (&base) ? base : base + CNT_W'(1);
`else
    incr = base + CNT_W'(1);
`endif
  end

  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    drain_d      = drain_q;
    s1_valid_d   = accept;
    s1_bin_d     = in_bin;
    fwd_valid_d  = s1_valid_q;
    fwd_bin_d    = s1_bin_q;
    fwd_cnt_d    = incr;
    fetch_idx_d  = fetch_idx_q;
    pend_valid_d = pend_valid_q;
    pend_idx_d   = pend_idx_q;
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    out_cnt_d    = out_cnt_q;
    out_last_d   = out_last_q;
    rd_addr      = in_bin;
    we           = s1_valid_q;
    wr_addr      = s1_bin_q;
    wr_data      = incr;

    case (state_q)
      S_INIT: begin
        we         = 1'b1;
        wr_addr    = init_idx_q;
        wr_data    = '0;
        init_idx_d = init_idx_q + BIN_W'(1);
        if (&init_idx_q) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        fetch_idx_d = '0;
        drain_d     = 1'b0;
        if (accept && i_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = S_READ;
      end
      S_READ: begin
        if (xfer) begin
          we      = 1'b1;
          wr_addr = out_idx_q;
          wr_data = '0;
          if (out_last_q) state_d = S_ACCUM;
        end
      end
      default: state_d = S_INIT;
    endcase

    // Readout: a prefetched RAM word waits in rd_data_q until the output register frees up.
    if (read_eng) begin
      if (load) begin
        out_valid_d = 1'b1;
        out_idx_d   = pend_idx_q;
        out_cnt_d   = rd_data_q;
        out_last_d  = &pend_idx_q;
      end else if (xfer) begin
        out_valid_d = 1'b0;
      end
      if (!pend_valid_q || load) begin
        if (!fetch_idx_q[BIN_W]) begin
          rd_addr      = fetch_idx_q[BIN_W-1:0];
          pend_valid_d = 1'b1;
          pend_idx_d   = fetch_idx_q[BIN_W-1:0];
          fetch_idx_d  = fetch_idx_q + (BIN_W+1)'(1);
        end else begin
          pend_valid_d = 1'b0;
        end
      end else begin
        rd_addr = pend_idx_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_INIT;
      init_idx_q   <= '0;
      drain_q      <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_bin_q     <= '0;
      fwd_valid_q  <= 1'b0;
      fwd_bin_q    <= '0;
      fwd_cnt_q    <= '0;
      fetch_idx_q  <= '0;
      pend_valid_q <= 1'b0;
      pend_idx_q   <= '0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_cnt_q    <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      drain_q      <= drain_d;
      s1_valid_q   <= s1_valid_d;
      s1_bin_q     <= s1_bin_d;
      fwd_valid_q  <= fwd_valid_d;
      fwd_bin_q    <= fwd_bin_d;
      fwd_cnt_q    <= fwd_cnt_d;
      fetch_idx_q  <= fetch_idx_d;
      pend_valid_q <= pend_valid_d;
      pend_idx_q   <= pend_idx_d;
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_cnt_q    <= out_cnt_d;
      out_last_q   <= out_last_d;
    end
  end

  assign o_bin_valid = out_valid_q;
  assign o_bin_idx   = out_idx_q;
  assign o_bin_count = out_cnt_q;
  assign o_bin_last  = out_last_q;

`ifdef HIST_SATURATE_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (s1_valid_q && (&base)) ovf_d = 1'b1;
    if (xfer && out_last_q)    ovf_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign o_overflow = ovf_q;
`else
  assign o_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_hist_accum.sv
// Directed bench for hist_accum: a default-size instance and a small 16-bin, 2-bit-count instance.
module tb_hist_accum;
`ifdef HIST_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, va, la, ra, rdy_a, bv_a, bl_a, ovf_a;
  logic [7:0]  da, bi_a;
  logic [15:0] bc_a;
  logic        rst_b, vb, lb, rb, rdy_b, bv_b, bl_b, ovf_b;
  logic [7:0]  db;
  logic [3:0]  bi_b;
  logic [1:0]  bc_b;

  hist_accum dut_a (
    .i_clk(clk), .i_reset(rst_a), .i_valid(va), .i_data(da), .i_last(la),
    .o_ready(rdy_a), .o_bin_valid(bv_a), .o_bin_idx(bi_a), .o_bin_count(bc_a),
    .o_bin_last(bl_a), .i_ready(ra), .o_overflow(ovf_a)
  );

  hist_accum #(.DATA_W(8), .BIN_W(4), .CNT_W(2)) dut_b (
    .i_clk(clk), .i_reset(rst_b), .i_valid(vb), .i_data(db), .i_last(lb),
    .o_ready(rdy_b), .o_bin_valid(bv_b), .o_bin_idx(bi_b), .o_bin_count(bc_b),
    .o_bin_last(bl_b), .i_ready(rb), .o_overflow(ovf_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_a [256];
  int exp_b [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic init_a();
    int n = 0;
    while (!rdy_a && n < 1000) begin
      chk("init_bv", bv_a, 0);
      @(negedge clk);
      n++;
    end
    chk("init_cycles", n, 256);
  endtask

  task automatic send_a(input logic [7:0] d, input logic l, input int gap);
    va = 1'b1; da = d; la = l;
    chk("rdy_a", rdy_a, 1);
    @(negedge clk);
    va = 1'b0; la = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_b(input logic [7:0] d, input logic l);
    vb = 1'b1; db = d; lb = l;
    chk("rdy_b", rdy_b, 1);
    @(negedge clk);
    vb = 1'b0; lb = 1'b0;
  endtask

  // Stall pattern 1,0,0,1 when stall is set; abort_at >= 0 raises reset when that bin is next.
  task automatic read_a(input bit stall, input int abort_at);
    int nxt = 0, lat = 1, cyc = 0;
    bit started = 0, held = 0, done = 0;
    logic [7:0] hi; logic [15:0] hc; logic hl;
    hi = '0; hc = '0; hl = 1'b0;
    while (!done) begin
      ra = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (abort_at >= 0 && nxt == abort_at) begin
        rst_a = 1'b1;
        done = 1;
      end else begin
        chk("rdy_rd", rdy_a, 0);
        if (held) begin
          chk("hold_v", bv_a, 1);
          chk("hold_idx", bi_a, hi);
          chk("hold_cnt", bc_a, hc);
          chk("hold_last", bl_a, hl);
        end
        if (bv_a) begin
          if (!started) begin
            started = 1;
            chk("latency_le4", lat <= 4, 1);
          end
          if (ra) begin
            chk("idx", bi_a, nxt);
            chk("cnt", bc_a, exp_a[nxt]);
            chk("last", bl_a, nxt == 255);
            nxt++;
          end
        end else if (started && !stall) begin
          chk("thru", bv_a, 1);
        end
        held = bv_a && !ra; hi = bi_a; hc = bc_a; hl = bl_a;
        if (nxt == 256) done = 1;
        else begin
          @(negedge clk);
          cyc++; lat++;
          if (cyc > 3000) begin chk("timeout_a", 0, 1); done = 1; end
        end
      end
    end
  endtask

  task automatic read_b();
    int nxt = 0, cyc = 0;
    bit done = 0;
    rb = 1'b1;
    while (!done) begin
      if (bv_b) begin
        chk("b_idx", bi_b, nxt);
        chk("b_cnt", bc_b, exp_b[nxt]);
        chk("b_last", bl_b, nxt == 15);
        nxt++;
      end
      if (nxt == 16) done = 1;
      else begin
        @(negedge clk);
        cyc++;
        if (cyc > 200) begin chk("timeout_b", 0, 1); done = 1; end
      end
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 256; i++) exp_a[i] = 0;
    for (int i = 0; i < 16; i++) exp_b[i] = 0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    va = 1'b0; la = 1'b0; da = '0; ra = 1'b1;
    vb = 1'b0; lb = 1'b0; db = '0; rb = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy_a, 0);
    chk("rst_bv", bv_a, 0);
    chk("rst_idx", bi_a, 0);
    chk("rst_cnt", bc_a, 0);
    chk("rst_last", bl_a, 0);
    chk("rst_ovf", ovf_a, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    init_a();
    chk("b_ready", rdy_b, 1);
    $display("init: dut_a ready after reset");

    clear_exp(); exp_a[5] = 3; exp_a[200] = 1;
    send_a(8'd5, 0, 0); send_a(8'd5, 0, 0); send_a(8'd5, 0, 0); send_a(8'd200, 1, 0);
    read_a(0, -1);
    @(negedge clk); chk("rdy_after1", rdy_a, 1);
    $display("frame 1: 5,5,5,200 read out");

    clear_exp(); exp_a[7] = 1;
    send_a(8'd7, 1, 0);
    read_a(1, -1);
    @(negedge clk); chk("rdy_after2", rdy_a, 1);
    $display("frame 2: single 7 read out with stalls");

    clear_exp(); exp_a[9] = 4; exp_a[10] = 1;
    send_a(8'd9, 0, 1); send_a(8'd9, 0, 0); send_a(8'd9, 0, 0);
    send_a(8'd10, 0, 0); send_a(8'd9, 1, 0);
    read_a(0, -1);
    @(negedge clk);
    $display("frame 3: forwarding mix read out");

    clear_exp(); exp_a[150] = 2;
    send_a(8'd150, 0, 0); send_a(8'd150, 1, 0);
    read_a(0, 100);
    @(negedge clk);
    chk("abort_bv", bv_a, 0);
    chk("abort_rdy", rdy_a, 0);
    rst_a = 1'b0;
    init_a();
    $display("frame 4: reset during readout at bin 100");

    clear_exp(); exp_a[150] = 1;
    send_a(8'd150, 1, 0);
    read_a(0, -1);
    @(negedge clk);
    $display("frame 5: single 150 after reset read out");

    clear_exp(); exp_b[1] = 2; exp_b[15] = 1;
    send_b(8'h10, 0); send_b(8'h1F, 0); send_b(8'hF0, 1);
    read_b();
    @(negedge clk); chk("b_rdy_after", rdy_b, 1);
    $display("frame b1: 0x10,0x1F,0xF0 read out");

    clear_exp(); exp_b[3] = SAT ? 3 : 1;
    for (int i = 0; i < 5; i++) send_b(8'h33, i == 4);
    chk("b_ovf_set", ovf_b, SAT);
    read_b();
    @(negedge clk); chk("b_ovf_clr", ovf_b, 0);
    $display("frame b2: five 0x33 read out");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
